// File: rtl/fma_round.sv
`default_nettype none
// ============================================================================
//  Module   : fma_round
//  Purpose  : Final exponent-adjust and round-to-nearest-even stage of the
//             single-precision FMA. Two registered stages (S1, S2) with a
//             valid/ready handshake; S1 adjusts the exponent and decides the
//             rounding increment, S2 applies it and packs the IEEE-754 result.
//  Ports    :
//    clk, rst                  clock, synchronous active-high reset
//    in_valid / in_ready       upstream handshake (in_ready is combinational)
//    sign_in, exp_in, m_in     sign, biased exponent, normalized mantissa
//    zero_cnt, en_in           normalization shift amount and direction
//    nan_in, inf_in            special-operand flags
//    out_valid / out_ready     downstream handshake
//    result                    packed single-precision result
//    flag_ovf/unf/inx          overflow, underflow, inexact (with out_valid)
//  Revision : 1.0  initial release
// ============================================================================
module fma_round #(
    parameter int EXP_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign_in,
    input  logic [EXP_W-1:0] exp_in,
    input  logic [26:0]      m_in,
    input  logic [5:0]       zero_cnt,
    input  logic             en_in,
    input  logic             nan_in,
    input  logic             inf_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             flag_ovf,
    output logic             flag_unf,
    output logic             flag_inx
);

    localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

    // S1 stage state
    logic             v1_q,     v1_d;
    logic             s1_sign_q, s1_sign_d;
    logic             s1_nan_q,  s1_nan_d;
    logic             s1_inf_q,  s1_inf_d;
    logic             s1_hid_q,  s1_hid_d;
    logic [22:0]      s1_frac_q, s1_frac_d;
    logic             s1_rup_q,  s1_rup_d;
    logic             s1_inx_q,  s1_inx_d;
    logic [EXP_W-1:0] s1_eadj_q, s1_eadj_d;

    // S2 stage state (drives the outputs directly)
    logic             v2_q,     v2_d;
    logic [31:0]      result_q, result_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;
    logic             inx_q,    inx_d;

    logic                    w_adv;
    logic [EXP_W-1:0]        w_zc_ext;
    logic                    w_carry;
    logic [22:0]             w_frac_fin;
    logic signed [EXP_W:0]   w_e_fin;
    logic [31:0]             w_res;
    logic                    w_ovf;
    logic                    w_unf;
    logic                    w_inx;

    always_comb begin
        w_adv    = !v2_q || out_ready;
        w_zc_ext = {{(EXP_W-6){1'b0}}, zero_cnt};

        // {1,frac} + r carries out exactly when frac + r overflows 23 bits,
        // and in that case the remaining fraction bits are already zero.
        {w_carry, w_frac_fin} = {1'b0, s1_frac_q} + {23'd0, s1_rup_q};

        // One extra bit so e_adj + 1 at the top of the range cannot wrap.
        w_e_fin = {s1_eadj_q[EXP_W-1], s1_eadj_q} + {{EXP_W{1'b0}}, w_carry};

        w_res = {s1_sign_q, 8'd0, w_frac_fin};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_inx = 1'b0;
        if (s1_nan_q) begin
            w_res = c_QNAN;
        end else if (s1_inf_q) begin
            w_res = {s1_sign_q, 8'hFF, 23'd0};
        end else if (!s1_hid_q) begin
            w_res = {s1_sign_q, 31'd0};
        end else if (w_e_fin >= 255) begin
            w_res = {s1_sign_q, 8'hFF, 23'd0};
            w_ovf = 1'b1;
            w_inx = 1'b1;
        end else if (w_e_fin <= 0) begin
            // No denormals: anything at or below exponent zero flushes.
            w_res = {s1_sign_q, 31'd0};
            w_unf = 1'b1;
            w_inx = 1'b1;
        end else begin
            w_res = {s1_sign_q, w_e_fin[7:0], w_frac_fin};
            w_inx = s1_inx_q;
        end

        v1_d      = v1_q;
        s1_sign_d = s1_sign_q;
        s1_nan_d  = s1_nan_q;
        s1_inf_d  = s1_inf_q;
        s1_hid_d  = s1_hid_q;
        s1_frac_d = s1_frac_q;
        s1_rup_d  = s1_rup_q;
        s1_inx_d  = s1_inx_q;
        s1_eadj_d = s1_eadj_q;
        v2_d      = v2_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        inx_d     = inx_q;

        // Both stages advance together, so a drain and a fill share a cycle.
        if (w_adv) begin
            v1_d      = in_valid;
            s1_sign_d = sign_in;
            s1_nan_d  = nan_in;
            s1_inf_d  = inf_in;
            s1_hid_d  = m_in[26];
            s1_frac_d = m_in[25:3];
            s1_rup_d  = m_in[2] & (m_in[1] | m_in[0] | m_in[3]);
            s1_inx_d  = |m_in[2:0];
            s1_eadj_d = en_in ? (exp_in + w_zc_ext) : (exp_in - w_zc_ext);
            v2_d      = v1_q;
            result_d  = w_res;
            ovf_d     = w_ovf;
            unf_d     = w_unf;
            inx_d     = w_inx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_nan_q  <= 1'b0;
            s1_inf_q  <= 1'b0;
            s1_hid_q  <= 1'b0;
            s1_frac_q <= '0;
            s1_rup_q  <= 1'b0;
            s1_inx_q  <= 1'b0;
            s1_eadj_q <= '0;
            v2_q      <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inx_q     <= 1'b0;
        end else begin
            v1_q      <= v1_d;
            s1_sign_q <= s1_sign_d;
            s1_nan_q  <= s1_nan_d;
            s1_inf_q  <= s1_inf_d;
            s1_hid_q  <= s1_hid_d;
            s1_frac_q <= s1_frac_d;
            s1_rup_q  <= s1_rup_d;
            s1_inx_q  <= s1_inx_d;
            s1_eadj_q <= s1_eadj_d;
            v2_q      <= v2_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            inx_q     <= inx_d;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = v2_q;
    assign result    = result_q;
    assign flag_ovf  = ovf_q;
    assign flag_unf  = unf_q;
    assign flag_inx  = inx_q;

endmodule
`default_nettype wire

// File: tb/tb_fma_round.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fma_round
//  Purpose  : Self-checking bench for fma_round: reset, directed rounding and
//             exponent cases, backpressure, mid-operation reset and a
//             randomized stream checked against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fma_round;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [26:0] m;
        logic [5:0]  zc;
        logic        en;
        logic        nan;
        logic        inf;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [9:0]  exp_in;
    logic [26:0] m_in;
    logic [5:0]  zero_cnt;
    logic        en_in;
    logic        nan_in;
    logic        inf_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_inx;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fma_round #(.EXP_W(10)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sign_in(sign_in), .exp_in(exp_in), .m_in(m_in),
        .zero_cnt(zero_cnt), .en_in(en_in),
        .nan_in(nan_in), .inf_in(inf_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inx(flag_inx)
    );

    // Reference: {result[31:0], ovf, unf, inx} from plain integer arithmetic.
    function automatic logic [34:0] ref_model(op_t o);
        int              e;
        int              q;
        int              rem;
        logic [31:0]     qv;
        logic [31:0]     ev;
        logic signed [9:0] ew;
        logic            inx;
        if (o.nan) return {32'h7FC0_0000, 3'b000};
        if (o.inf) return {o.sign, 8'hFF, 23'd0, 3'b000};
        if (!o.m[26]) return {o.sign, 31'd0, 3'b000};
        e  = $signed(o.exp);
        e  = o.en ? e + int'(o.zc) : e - int'(o.zc);
        ev = e;
        ew = ev[9:0];
        e  = ew;
        q   = int'(o.m >> 3);
        rem = int'(o.m & 27'd7);
        inx = (rem != 0);
        if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
        if (q == (1 << 24)) begin
            q = q / 2;
            e = e + 1;
        end
        if (e >= 255) return {o.sign, 8'hFF, 23'd0, 3'b101};
        if (e <= 0)   return {o.sign, 31'd0, 3'b011};
        qv = q;
        ev = e;
        return {o.sign, ev[7:0], qv[22:0], 2'b00, inx};
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  r;
        r      = $urandom_range(0, 15);
        o.sign = 1'($urandom);
        o.nan  = (r == 0);
        o.inf  = (r == 1);
        o.m    = {1'b1, 26'($urandom)};
        if (r == 2) o.m = {1'b0, 26'($urandom)};
        if (r == 3) o.m = 27'h7FF_FFF8 | 27'($urandom_range(0, 7));
        o.exp  = 10'($urandom_range(0, 400));
        if (r == 4) o.exp = 10'($urandom_range(0, 1023));
        o.zc   = 6'($urandom_range(0, 40));
        o.en   = 1'($urandom);
        return o;
    endfunction

    task automatic drive(op_t o, logic v);
        in_valid = v;
        sign_in  = o.sign;
        exp_in   = o.exp;
        m_in     = o.m;
        zero_cnt = o.zc;
        en_in    = o.en;
        nan_in   = o.nan;
        inf_in   = o.inf;
    endtask

    task automatic test_reset();
        op_t o;
        o = rand_op();
        o.nan = 1'b0;
        o.inf = 1'b0;
        rst = 1'b1;
        out_ready = 1'b1;
        drive(o, 1'b1);
        repeat (3) @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid actual=%b required=0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if ({result, flag_ovf, flag_unf, flag_inx} !== 35'd0)
            $display("FAIL reset_result actual=%h/%b%b%b required=0", result, flag_ovf, flag_unf, flag_inx);
        else pass_cnt++;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL post_reset_ready actual=%b/%b required=1/0", in_ready, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        op_t         o;
        logic [31:0] exp_r;
        logic [2:0]  exp_f;
        for (int i = 0; i < 9; i++) begin
            o = '0;
            o.exp = 10'd127;
            o.m   = 27'h400_0000;
            case (i)
                0: begin exp_r = 32'h3F80_0000; exp_f = 3'b000; end
                1: begin o.m = 27'h400_0004; exp_r = 32'h3F80_0000; exp_f = 3'b001; end
                2: begin o.m = 27'h400_000C; exp_r = 32'h3F80_0002; exp_f = 3'b001; end
                3: begin o.m = 27'h7FF_FFFF; exp_r = 32'h4000_0000; exp_f = 3'b001; end
                4: begin o.exp = 10'd130; o.en = 1'b1; o.zc = 6'd3;
                         exp_r = 32'h4280_0000; exp_f = 3'b000; end
                5: begin o.exp = 10'd253; o.en = 1'b1; o.zc = 6'd3;
                         exp_r = 32'h7F80_0000; exp_f = 3'b101; end
                6: begin o.sign = 1'b1; o.exp = 10'd2; o.zc = 6'd5;
                         exp_r = 32'h8000_0000; exp_f = 3'b011; end
                7: begin o.nan = 1'b1; o.m = 27'h7FF_FFFF; exp_r = 32'h7FC0_0000; exp_f = 3'b000; end
                default: begin o.sign = 1'b1; o.inf = 1'b1;
                         exp_r = 32'hFF80_0000; exp_f = 3'b000; end
            endcase
            @(negedge clk);
            out_ready = 1'b1;
            drive(o, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL dir%0d_early_valid actual=%b required=0", i, out_valid);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || result !== exp_r || {flag_ovf, flag_unf, flag_inx} !== exp_f)
                $display("FAIL dir%0d_result actual=%b/%h/%b%b%b required=1/%h/%b",
                         i, out_valid, result, flag_ovf, flag_unf, flag_inx, exp_r, exp_f);
            else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        op_t         a, b, c;
        logic [34:0] ea, eb, ec;
        a = rand_op(); b = rand_op(); c = rand_op();
        ea = ref_model(a); eb = ref_model(b); ec = ref_model(c);
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        drive(a, 1'b1);
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_a actual=%b required=1", in_ready);
        else pass_cnt++;
        @(negedge clk);
        drive(b, 1'b1);
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_b actual=%b required=1", in_ready);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(c, 1'b1);
            #1;
            total_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 ||
                {result, flag_ovf, flag_unf, flag_inx} !== ea)
                $display("FAIL bp_hold%0d actual=%b/%b/%h required=0/1/%h", k, in_ready, out_valid,
                         {result, flag_ovf, flag_unf, flag_inx}, ea);
            else pass_cnt++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || {result, flag_ovf, flag_unf, flag_inx} !== ea)
            $display("FAIL bp_release actual=%b/%h required=1/%h", in_ready,
                     {result, flag_ovf, flag_unf, flag_inx}, ea);
        else pass_cnt++;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || {result, flag_ovf, flag_unf, flag_inx} !== eb)
            $display("FAIL bp_second actual=%b/%h required=1/%h", out_valid,
                     {result, flag_ovf, flag_unf, flag_inx}, eb);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b1 || {result, flag_ovf, flag_unf, flag_inx} !== ec)
            $display("FAIL bp_third actual=%b/%h required=1/%h", out_valid,
                     {result, flag_ovf, flag_unf, flag_inx}, ec);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_no_extra actual=%b required=0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        out_ready = 1'b0;
        drive(rand_op(), 1'b1);
        @(negedge clk);
        drive(rand_op(), 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL midrst_loaded actual=%b required=1", out_valid);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || result !== 32'd0)
            $display("FAIL midrst_cleared actual=%b/%h required=0/00000000", out_valid, result);
        else pass_cnt++;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL midrst_stale%0d actual=%b required=0", k, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_random_stream();
        localparam int N = 300;
        logic [34:0] q[$];
        logic [34:0] exp_v;
        logic [34:0] held;
        op_t         cur;
        bit          have  = 0;
        bit          stall = 0;
        int          sent  = 0;
        int          recv  = 0;
        int          cyc   = 0;
        cur = '0;
        held = '0;
        while ((sent < N || q.size() > 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (stall) begin
                total_cnt++;
                if (out_valid !== 1'b1 || {result, flag_ovf, flag_unf, flag_inx} !== held)
                    $display("FAIL rnd_stable actual=%b/%h required=1/%h", out_valid,
                             {result, flag_ovf, flag_unf, flag_inx}, held);
                else pass_cnt++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            stall = 0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    total_cnt++;
                    recv++;
                    if (q.size() == 0) begin
                        $display("FAIL rnd_unexpected actual=%h required=none",
                                 {result, flag_ovf, flag_unf, flag_inx});
                    end else begin
                        exp_v = q.pop_front();
                        if ({result, flag_ovf, flag_unf, flag_inx} !== exp_v)
                            $display("FAIL rnd_result%0d actual=%h required=%h", recv,
                                     {result, flag_ovf, flag_unf, flag_inx}, exp_v);
                        else pass_cnt++;
                    end
                end else begin
                    stall = 1;
                    held  = {result, flag_ovf, flag_unf, flag_inx};
                end
            end
            if (sent < N && $urandom_range(0, 4) != 0) begin
                if (!have) begin
                    cur  = rand_op();
                    have = 1;
                end
                drive(cur, 1'b1);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                q.push_back(ref_model(cur));
                sent++;
                have = 0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (sent != N || recv != N || q.size() != 0 || out_valid !== 1'b0)
            $display("FAIL rnd_complete actual=sent%0d/recv%0d/left%0d required=%0d/%0d/0",
                     sent, recv, q.size(), N, N);
        else pass_cnt++;
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        drive('0, 1'b0);
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_random_stream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fma_round.md
FMA_ROUND -- requirements
Module: fma_round

Interface
REQ-001 The block SHALL have one parameter: EXP_W, default 10, width of the signed two's-complement biased exponent path.
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  upstream normalize stage presents a valid operand.
REQ-005 in_ready  out  1  block accepts the operand this cycle.
REQ-006 sign_in  in  1  result sign.
REQ-007 exp_in  in  EXP_W  signed biased exponent before normalization shift.
REQ-008 m_in  in  27  normalized mantissa from normalize: [26] hidden bit, [25:3] fraction, [2] guard, [1] round, [0] sticky.
REQ-009 zero_cnt  in  6  normalization shift amount from normalize.
REQ-010 en_in  in  1  shift direction from normalize: 1 = right-shifted (exponent up), 0 = left-shifted (exponent down).
REQ-011 nan_in, inf_in  in  1 each  special-operand flags from the special-case path.
REQ-012 out_valid  out  1  result valid.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 result  out  32  IEEE-754 single-precision result.
REQ-015 flag_ovf, flag_unf, flag_inx  out  1 each  overflow, underflow, inexact; valid with out_valid.

Function
REQ-016 Pipeline SHALL be two registered stages (S1, S2) with valid bits v1, v2; out_valid = v2; all outputs registered.
REQ-017 adv = !v2 | out_ready; in_ready = adv (combinational); when adv, S1 captures inputs and v1 <= in_valid, S2 captures S1 and v2 <= v1; when !adv all stage registers hold.
REQ-018 Latency SHALL be 2 cycles from accepted input to out_valid with out_ready held high; throughput one result per cycle.
REQ-019 While out_valid=1 and out_ready=0, result and flags SHALL remain stable; no operand is lost, duplicated or reordered.
REQ-020 S1: e_adj = exp_in + zero_cnt if en_in else exp_in - zero_cnt, zero_cnt zero-extended, EXP_W-bit signed.
REQ-021 S1: round_up = G & (R | S | m_in[3]) (round-to-nearest-even); inexact = G | R | S.
REQ-022 S2: 24-bit sum {1, frac} + round_up; on carry-out, fraction = 0 and e_fin = e_adj + 1, else e_fin = e_adj.
REQ-023 S2 output selection, priority highest first:
- nan_in: result 0x7FC00000, flags 0.
- inf_in: {sign, 0xFF, 0}, flags 0.
- m_in[26]=0: signed zero, flags 0.
- e_fin >= 255: {sign, 0xFF, 0}, flag_ovf=1, flag_inx=1.
- e_fin <= 0: signed zero (flush), flag_unf=1, flag_inx=1.
- otherwise: {sign, e_fin[7:0], fraction}, flag_inx = inexact.
REQ-024 Denormal results SHALL NOT be produced; an exponent equal to 0 after rounding SHALL flush.
REQ-025 Simultaneous S2 drain and S1 fill in one cycle SHALL be supported without bubble.

Reset
REQ-026 On rst=1 at a clock edge: v1=0, v2=0, result=0, all flags 0; in_ready=1 from the cycle after reset.
REQ-027 Inputs SHALL be ignored while rst=1; rst asserted mid-operation discards in-flight operands, and none is emitted afterwards.

Verification
REQ-028 1.0: sign 0, exp_in=127, m_in=27'h4000000, zero_cnt=0, en_in=0, out_ready=1 -> 2 cycles later result 0x3F800000, flags 0.
REQ-029 Tie to even: exp 127, m_in=27'h4000004 (G only) -> 0x3F800000, inx=1; m_in=27'h400000C (lsb=1, G) -> 0x3F800002, inx=1.
REQ-030 Round carry: exp 127, m_in=27'h7FFFFFF -> 0x40000000, inx=1.
REQ-031 Exponent adjust:
- exp 130, en_in=1, zero_cnt=3, m_in=27'h4000000 -> 0x42800000.
- exp 253, en_in=1, zero_cnt=3 -> 0x7F800000, ovf=1, inx=1.
- sign 1, exp 2, en_in=0, zero_cnt=5 -> 0x80000000, unf=1, inx=1.
REQ-032 Backpressure: three back-to-back inputs, out_ready=0 for 3 cycles -> in_ready drops once v2=1; result held stable; after release all three emerge in order, none lost or duplicated.
REQ-033 Reset mid-op: rst pulsed with v1=v2=1 -> out_valid=0 the next cycle; no stale result appears afterwards.
